// File: rtl/ecc_65_rd_stage.sv
// ecc_65_rd_stage: registered read-side stage behind the 65-bit SECDED decoder.
// Buffers corrected beats in a 2-entry valid/ready FIFO. Uncorrectable beats
// leave the stage with a poison bit set. The stage also keeps saturating SBE/DBE
// counters and a first-error address log for CSR readout.
module ecc_65_rd_stage #(
    parameter int unsigned DATA_WIDTH = 65,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Decoder side
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    // Consumer side
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_poison,
    // CSR side
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  sbe_cnt,
    output logic [CNT_WIDTH-1:0]  dbe_cnt,
    output logic                  log_vld,
    output logic                  log_dbe,
    output logic [ADDR_WIDTH-1:0] log_addr
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] mem_data_q [2];
    logic [DATA_WIDTH-1:0] mem_data_d [2];
    logic [1:0]            mem_poison_q, mem_poison_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  in_rdy_q, in_rdy_d;

    // Error bookkeeping
    logic [CNT_WIDTH-1:0]  sbe_cnt_q, sbe_cnt_d;
    logic [CNT_WIDTH-1:0]  dbe_cnt_q, dbe_cnt_d;
    logic                  log_vld_q, log_vld_d;
    logic                  log_dbe_q, log_dbe_d;
    logic [ADDR_WIDTH-1:0] log_addr_q, log_addr_d;

    logic push, pop;
    logic sbe_push, dbe_push, err_push;

    // Handshake qualification; in_rdy_q already encodes occupancy < 2
    always_comb begin
        push     = in_vld & in_rdy_q;
        pop      = (occ_q != 2'd0) & out_rdy;
        dbe_push = push & in_dbit_err;
        sbe_push = push & in_sbit_err & ~in_dbit_err;
        err_push = sbe_push | dbe_push;
    end

    // FIFO next state: write at tail, advance head, track occupancy
    always_comb begin
        mem_data_d   = mem_data_q;
        mem_poison_d = mem_poison_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        if (push) begin
            mem_data_d[wr_ptr_q]   = in_data;
            mem_poison_d[wr_ptr_q] = in_dbit_err;
            wr_ptr_d               = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Registered ready: looks only at next occupancy, never at inputs
        in_rdy_d = (occ_d < 2'd2);
    end

    // Error counters: saturate at all-ones; clr wins but keeps a same-cycle event
    always_comb begin
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (clr) begin
            sbe_cnt_d = sbe_push ? CntOne : '0;
            dbe_cnt_d = dbe_push ? CntOne : '0;
        end else begin
            if (sbe_push && (sbe_cnt_q != CntMax)) begin
                sbe_cnt_d = sbe_cnt_q + CntOne;
            end
            if (dbe_push && (dbe_cnt_q != CntMax)) begin
                dbe_cnt_d = dbe_cnt_q + CntOne;
            end
        end
    end

    // First-error log: capture when empty, upgrade SBE entry to DBE, else hold
    always_comb begin
        log_vld_d  = log_vld_q;
        log_dbe_d  = log_dbe_q;
        log_addr_d = log_addr_q;
        if (clr) begin
            log_vld_d  = err_push;
            log_dbe_d  = dbe_push;
            log_addr_d = err_push ? in_addr : '0;
        end else if (err_push && !log_vld_q) begin
            log_vld_d  = 1'b1;
            log_dbe_d  = dbe_push;
            log_addr_d = in_addr;
        end else if (dbe_push && log_vld_q && !log_dbe_q) begin
            log_dbe_d  = 1'b1;
            log_addr_d = in_addr;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_data_q[0] <= '0;
            mem_data_q[1] <= '0;
            mem_poison_q  <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            in_rdy_q      <= 1'b1;
            sbe_cnt_q     <= '0;
            dbe_cnt_q     <= '0;
            log_vld_q     <= 1'b0;
            log_dbe_q     <= 1'b0;
            log_addr_q    <= '0;
        end else begin
            mem_data_q[0] <= mem_data_d[0];
            mem_data_q[1] <= mem_data_d[1];
            mem_poison_q  <= mem_poison_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            in_rdy_q      <= in_rdy_d;
            sbe_cnt_q     <= sbe_cnt_d;
            dbe_cnt_q     <= dbe_cnt_d;
            log_vld_q     <= log_vld_d;
            log_dbe_q     <= log_dbe_d;
            log_addr_q    <= log_addr_d;
        end
    end

    // Outputs straight from registers; head entry is stable until popped
    always_comb begin
        in_rdy     = in_rdy_q;
        out_vld    = (occ_q != 2'd0);
        out_data   = mem_data_q[rd_ptr_q];
        out_poison = mem_poison_q[rd_ptr_q];
        sbe_cnt    = sbe_cnt_q;
        dbe_cnt    = dbe_cnt_q;
        log_vld    = log_vld_q;
        log_dbe    = log_dbe_q;
        log_addr   = log_addr_q;
    end

endmodule

// File: tb/tb_ecc_65_rd_stage.sv
// Bench for ecc_65_rd_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model. Counters built 4 bits wide so that
// saturation is reachable.
module tb_ecc_65_rd_stage;

    localparam int DW   = 65;
    localparam int AW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          in_sbit_err;
    logic          in_dbit_err;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic          out_poison;
    logic          clr;
    logic [CW-1:0] sbe_cnt;
    logic [CW-1:0] dbe_cnt;
    logic          log_vld;
    logic          log_dbe;
    logic [AW-1:0] log_addr;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW:0]   mq[$];  // {poison, data}
    int            m_sbe, m_dbe;
    logic          m_lv, m_ld;
    logic [AW-1:0] m_la;

    ecc_65_rd_stage #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_sbit_err (in_sbit_err),
        .in_dbit_err (in_dbit_err),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_poison  (out_poison),
        .clr         (clr),
        .sbe_cnt     (sbe_cnt),
        .dbe_cnt     (dbe_cnt),
        .log_vld     (log_vld),
        .log_dbe     (log_dbe),
        .log_addr    (log_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // One clock: update the model from the inputs seen at the edge, return at negedge
    task automatic step();
        bit push, pop, sbe_ev, dbe_ev, err;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_sbe = 0; m_dbe = 0;
            m_lv = 1'b0; m_ld = 1'b0; m_la = '0;
        end else begin
            push   = in_vld && (mq.size() < 2);
            pop    = (mq.size() != 0) && out_rdy;
            sbe_ev = push && in_sbit_err && !in_dbit_err;
            dbe_ev = push && in_dbit_err;
            err    = sbe_ev || dbe_ev;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({in_dbit_err, in_data});
            if (clr) begin
                m_sbe = sbe_ev ? 1 : 0;
                m_dbe = dbe_ev ? 1 : 0;
                m_lv  = err;
                m_ld  = dbe_ev;
                m_la  = err ? in_addr : '0;
            end else begin
                if (sbe_ev && m_sbe < CMAX) m_sbe++;
                if (dbe_ev && m_dbe < CMAX) m_dbe++;
                if (err && (!m_lv || (!m_ld && dbe_ev))) begin
                    m_lv = 1'b1;
                    m_ld = dbe_ev;
                    m_la = in_addr;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic s, input logic db);
        in_vld = 1'b1; in_addr = a; in_data = d; in_sbit_err = s; in_dbit_err = db;
    endtask

    task automatic idle_in();
        in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b1; in_addr = 8'hAA; in_data = rand_data();
        in_sbit_err = 1'b1; in_dbit_err = 1'b1; out_rdy = 1'b0; clr = 1'b0;
        repeat (3) step();
        vectors++;
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        vectors++;
        if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        vectors++;
        if (sbe_cnt !== 4'd0 || dbe_cnt !== 4'd0) begin
            miscompares++; $display("FAIL reset_cnt: got sbe=%0d dbe=%0d want 0/0", sbe_cnt, dbe_cnt);
        end
        vectors++;
        if (log_vld !== 1'b0 || log_dbe !== 1'b0 || log_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_log: got vld=%b dbe=%b addr=%h want 0/0/00", log_vld, log_dbe, log_addr);
        end
        vectors++;
        if (out_data !== '0 || out_poison !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_data: got %h/%b want 0/0", out_data, out_poison);
        end
        idle_in();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] d;
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = rand_data();
            drive_beat(AW'(i), d, 1'b0, 1'b0);
            step();
            vectors++;
            if (out_vld !== 1'b1 || out_data !== d || out_poison !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_beat%0d: got vld=%b data=%h want vld=1 data=%h", i, out_vld, out_data, d);
            end
            vectors++;
            if (in_rdy !== 1'b1 || sbe_cnt !== 4'd0 || dbe_cnt !== 4'd0) begin
                miscompares++;
                $display("FAIL stream_rdy_cnt%0d: got rdy=%b sbe=%0d dbe=%0d want 1/0/0", i, in_rdy, sbe_cnt, dbe_cnt);
            end
        end
        idle_in();
        step();
        vectors++;
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got vld=%b want 0", out_vld); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b, c;
        logic [DW-1:0] got[$];
        bit pushed_c;
        a = rand_data(); b = rand_data(); c = rand_data();
        out_rdy = 1'b0;
        drive_beat(8'h01, a, 1'b0, 1'b0);
        step();
        vectors++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b1 || out_data !== a) begin
            miscompares++; $display("FAIL bp_after_a: got rdy=%b vld=%b data=%h want 1/1/%h", in_rdy, out_vld, out_data, a);
        end
        drive_beat(8'h02, b, 1'b0, 1'b0);
        step();
        vectors++;
        if (in_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_full_rdy: got %b want 0", in_rdy); end
        drive_beat(8'h03, c, 1'b0, 1'b0);
        step();
        vectors++;
        if (in_rdy !== 1'b0 || out_data !== a) begin
            miscompares++; $display("FAIL bp_hold: got rdy=%b data=%h want 0/%h", in_rdy, out_data, a);
        end
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
            pushed_c = in_vld && in_rdy;
            if (out_vld) got.push_back(out_data);
            step();
            if (pushed_c) idle_in();
        end
        vectors++;
        if (got.size() != 3) begin
            miscompares++; $display("FAIL bp_count: got %0d beats want 3", got.size());
        end else begin
            vectors++;
            if (got[0] !== a || got[1] !== b || got[2] !== c) begin
                miscompares++;
                $display("FAIL bp_order: got %h %h %h want %h %h %h", got[0], got[1], got[2], a, b, c);
            end
        end
        vectors++;
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: got vld=%b want 0", out_vld); end
        idle_in();
    endtask

    task automatic test_error_log();
        logic [DW-1:0] d;
        out_rdy = 1'b1;
        drive_beat(8'h12, rand_data(), 1'b1, 1'b0);
        step();
        drive_beat(8'h34, rand_data(), 1'b1, 1'b0);
        step();
        d = rand_data();
        drive_beat(8'h56, d, 1'b0, 1'b1);
        step();
        vectors++;
        if (out_vld !== 1'b1 || out_poison !== 1'b1 || out_data !== d) begin
            miscompares++;
            $display("FAIL err_poison: got vld=%b poison=%b data=%h want 1/1/%h", out_vld, out_poison, out_data, d);
        end
        idle_in();
        step();
        vectors++;
        if (sbe_cnt !== 4'd2 || dbe_cnt !== 4'd1) begin
            miscompares++; $display("FAIL err_cnt: got sbe=%0d dbe=%0d want 2/1", sbe_cnt, dbe_cnt);
        end
        vectors++;
        if (log_vld !== 1'b1 || log_dbe !== 1'b1 || log_addr !== 8'h56) begin
            miscompares++;
            $display("FAIL err_log: got vld=%b dbe=%b addr=%h want 1/1/56", log_vld, log_dbe, log_addr);
        end
    endtask

    task automatic test_saturation();
        out_rdy = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        vectors++;
        if (sbe_cnt !== 4'd0 || dbe_cnt !== 4'd0 || log_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_plain: got sbe=%0d dbe=%0d lv=%b want 0/0/0", sbe_cnt, dbe_cnt, log_vld);
        end
        for (int i = 0; i < 17; i++) begin
            drive_beat(AW'(8'h40 + i), rand_data(), 1'b1, 1'b0);
            step();
        end
        idle_in();
        vectors++;
        if (sbe_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_sbe: got %0d want 15", sbe_cnt); end
        vectors++;
        if (log_vld !== 1'b1 || log_dbe !== 1'b0 || log_addr !== 8'h40) begin
            miscompares++;
            $display("FAIL sat_log: got vld=%b dbe=%b addr=%h want 1/0/40", log_vld, log_dbe, log_addr);
        end
        clr = 1'b1;
        drive_beat(8'h77, rand_data(), 1'b1, 1'b0);
        step();
        clr = 1'b0;
        idle_in();
        vectors++;
        if (sbe_cnt !== 4'd1 || dbe_cnt !== 4'd0) begin
            miscompares++; $display("FAIL clr_push_cnt: got sbe=%0d dbe=%0d want 1/0", sbe_cnt, dbe_cnt);
        end
        vectors++;
        if (log_vld !== 1'b1 || log_dbe !== 1'b0 || log_addr !== 8'h77) begin
            miscompares++;
            $display("FAIL clr_push_log: got vld=%b dbe=%b addr=%h want 1/0/77", log_vld, log_dbe, log_addr);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        out_rdy = 1'b0;
        drive_beat(8'h21, rand_data(), 1'b0, 1'b1);
        step();
        drive_beat(8'h22, rand_data(), 1'b1, 1'b0);
        step();
        idle_in();
        vectors++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b1 || sbe_cnt === 4'd0 || dbe_cnt === 4'd0) begin
            miscompares++;
            $display("FAIL mid_prefill: got rdy=%b vld=%b sbe=%0d dbe=%0d want 0/1/nonzero/nonzero",
                     in_rdy, out_vld, sbe_cnt, dbe_cnt);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || sbe_cnt !== 4'd0 || dbe_cnt !== 4'd0 || log_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got vld=%b rdy=%b sbe=%0d dbe=%0d lv=%b want 0/1/0/0/0",
                     out_vld, in_rdy, sbe_cnt, dbe_cnt, log_vld);
        end
        out_rdy = 1'b1;
        d = rand_data();
        drive_beat(8'h99, d, 1'b0, 1'b0);
        step();
        idle_in();
        vectors++;
        if (out_vld !== 1'b1 || out_data !== d || out_poison !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_next_beat: got vld=%b data=%h want 1/%h", out_vld, out_data, d);
        end
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            clr         = ($urandom_range(0, 24) == 0);
            in_vld      = $urandom_range(0, 2) != 0;
            in_addr     = AW'($urandom());
            in_data     = rand_data();
            in_sbit_err = $urandom_range(0, 2) == 0;
            in_dbit_err = $urandom_range(0, 5) == 0;
            out_rdy     = $urandom_range(0, 2) != 0;
            step();
            vectors++;
            if (out_vld !== (mq.size() != 0) || in_rdy !== (mq.size() < 2)) begin
                miscompares++;
                $display("FAIL rnd_hs@%0d: got vld=%b rdy=%b want occ=%0d", cyc, out_vld, in_rdy, mq.size());
            end
            if (mq.size() != 0) begin
                vectors++;
                if ({out_poison, out_data} !== mq[0]) begin
                    miscompares++;
                    $display("FAIL rnd_head@%0d: got %h want %h", cyc, {out_poison, out_data}, mq[0]);
                end
            end
            vectors++;
            if (int'(sbe_cnt) != m_sbe || int'(dbe_cnt) != m_dbe) begin
                miscompares++;
                $display("FAIL rnd_cnt@%0d: got sbe=%0d dbe=%0d want %0d/%0d", cyc, sbe_cnt, dbe_cnt, m_sbe, m_dbe);
            end
            vectors++;
            if (log_vld !== m_lv || log_dbe !== m_ld || log_addr !== m_la) begin
                miscompares++;
                $display("FAIL rnd_log@%0d: got %b/%b/%h want %b/%b/%h", cyc, log_vld, log_dbe, log_addr,
                         m_lv, m_ld, m_la);
            end
        end
        rst_n = 1'b1; clr = 1'b0; idle_in();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_error_log();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
